// File: rtl/arith_unit_serial.sv
// Digit-serial ADD/SUB/ACC unit: DIGIT result bits per cycle, LSB slice first.
// Latency: start sampled at edge k -> done pulse in the cycle after edge k+N+1 (N = WIDTH/DIGIT).
// Backpressure: none; start is only sampled in IDLE, so back-to-back throughput is one op per N+2 cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, op, a, b,      request, opcode (00 NOP, 01 ADD, 10 SUB, 11 ACC),
//   carry_in              operands and carry-in (borrow-in for SUB), latched on acceptance
//   busy, done            operation in progress / one-cycle completion pulse
//   y, carry_out,         registered result and flags, updated only with done
//   overflow, zero
//
// Build option: define ARITH_SAT_EN to saturate y on signed overflow instead of wrapping.
// WIDTH must be a multiple of DIGIT and at least 4.
module arith_unit_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } stateType;

    stateType state, stateNext;

    logic             busyNext;
    logic             doneNext;
    logic             loadOps;
    logic             stepDigit;
    logic             finishOp;

    // Operands are pre-conditioned at acceptance so every opcode becomes a
    // plain addition opA + opB + carry: SUB inverts b and the borrow, ACC
    // feeds back the current y, NOP adds zeros.
    logic [WIDTH-1:0] selA;
    logic [WIDTH-1:0] selB;
    logic             selC;

    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] sumReg;
    logic             carryReg;
    logic [CW-1:0]    digCnt;

    int               sliceBase;
    logic [DIGIT-1:0] sliceA;
    logic [DIGIT-1:0] sliceB;
    logic [DIGIT:0]   digitSum;

    logic             carryIntoMsb;
    logic             ovfRaw;
    logic [WIDTH-1:0] yFinal;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= stateNext;
            busy  <= busyNext;
            done  <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        loadOps   = 1'b0;
        stepDigit = 1'b0;
        finishOp  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = RUN;
                    loadOps   = 1'b1;
                end
            end
            RUN: begin
                stepDigit = 1'b1;
                if (digCnt == LAST_DIGIT) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                finishOp  = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        // busy and done are registered one cycle behind the FSM, so the
        // done pulse coincides with the cycle the new y first appears.
        busyNext = (state != IDLE);
        doneNext = finishOp;
    end

    // ------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------
    always_comb begin
        selA = '0;
        selB = '0;
        selC = 1'b0;
        case (op)
            OP_ADD: begin
                selA = a;
                selB = b;
                selC = carry_in;
            end
            OP_SUB: begin
                selA = a;
                selB = ~b;
                selC = ~carry_in;
            end
            OP_ACC: begin
                selA = y;
                selB = a;
                selC = carry_in;
            end
            OP_NOP: begin
                selA = '0;
                selB = '0;
                selC = 1'b0;
            end
            default: begin
                selA = '0;
                selB = '0;
                selC = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit adder
    // ------------------------------------------------------------------
    always_comb begin
        sliceBase = int'(digCnt) * DIGIT;
        sliceA    = opA[sliceBase +: DIGIT];
        sliceB    = opB[sliceBase +: DIGIT];
        digitSum  = {1'b0, sliceA} + {1'b0, sliceB} + {{DIGIT{1'b0}}, carryReg};
    end

    // ------------------------------------------------------------------
    // Final flags. The carry into the MSB is recovered from the MSB sum bit
    // (s = a ^ b ^ cin), which avoids tracking it inside the last digit.
    // ------------------------------------------------------------------
    always_comb begin
        carryIntoMsb = opA[WIDTH-1] ^ opB[WIDTH-1] ^ sumReg[WIDTH-1];
        ovfRaw       = carryReg ^ carryIntoMsb;
        yFinal       = sumReg;
`ifdef ARITH_SAT_EN
        // A set MSB on overflow means two non-negative operands wrapped
        // negative, i.e. positive overflow.
        if (ovfRaw) begin
            yFinal = sumReg[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                     : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA       <= '0;
            opB       <= '0;
            sumReg    <= '0;
            carryReg  <= 1'b0;
            digCnt    <= '0;
            y         <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            if (loadOps) begin
                opA      <= selA;
                opB      <= selB;
                carryReg <= selC;
                digCnt   <= '0;
            end
            if (stepDigit) begin
                sumReg[sliceBase +: DIGIT] <= digitSum[DIGIT-1:0];
                carryReg                   <= digitSum[DIGIT];
                digCnt                     <= digCnt + CW'(1);
            end
            if (finishOp) begin
                y         <= yFinal;
                carry_out <= carryReg;
                overflow  <= ovfRaw;
                zero      <= (yFinal == '0);
            end
        end
    end

endmodule

// File: tb/tb_arith_unit_serial.sv
// Randomized and directed bench for arith_unit_serial (WIDTH=8, DIGIT=4).
// Expected results come from plain integer arithmetic on the operands.
// Ends with a single summary line.
module tb_arith_unit_serial;

    localparam int W = 8;
    localparam int N = 2;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] y;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int           checkCount = 0;
    int           errorCount = 0;
    logic [W-1:0] yModel = '0;

    always #5 clk = ~clk;

    arith_unit_serial #(.WIDTH(W), .DIGIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .y         (y),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: true integer sum and true signed sum of the operation.
    task automatic calcExp(input logic [1:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input logic ci, output logic [W-1:0] eY, output logic eC,
                           output logic eO, output logic eZ);
        int full;
        int s;
        case (o)
            OP_ADD: begin
                full = int'(ai) + int'(bi) + int'(ci);
                s    = int'($signed(ai)) + int'($signed(bi)) + int'(ci);
            end
            OP_SUB: begin
                full = int'(ai) + (255 - int'(bi)) + (1 - int'(ci));
                s    = int'($signed(ai)) - int'($signed(bi)) - int'(ci);
            end
            OP_ACC: begin
                full = int'(yModel) + int'(ai) + int'(ci);
                s    = int'($signed(yModel)) + int'($signed(ai)) + int'(ci);
            end
            default: begin
                full = 0;
                s    = 0;
            end
        endcase
        eY = full[7:0];
        eC = full[8];
        eO = (s > 127) || (s < -128);
`ifdef ARITH_SAT_EN
        if (eO) eY = (s > 127) ? 8'h7F : 8'h80;
`endif
        eZ = (eY == 8'h00);
    endtask

    task automatic runOp(input logic [1:0] o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic ci);
        logic [W-1:0] eY;
        logic         eC, eO, eZ;
        int           lat;
        calcExp(o, ai, bi, ci, eY, eC, eO, eZ);
        @(negedge clk);
        start = 1'b1; op = o; a = ai; b = bi; carry_in = ci;
        @(posedge clk);                       // acceptance edge k
        #1;
        start = 1'b0;
        op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) checkVal("busy_run", busy, 1);
            if (done) begin
                lat = i;
                break;
            end
            op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); carry_in = 1'($urandom);
        end
        if (lat == 0) begin
            checkVal("done_timeout", 0, 1);
        end else begin
            checkVal("latency", lat, N + 1);
            checkVal("y", y, eY);
            checkVal("carry_out", carry_out, eC);
            checkVal("overflow", overflow, eO);
            checkVal("zero", zero, eZ);
            checkVal("busy_done", busy, 1);
            @(posedge clk);
            @(negedge clk);
            checkVal("done_pulse", done, 0);
            checkVal("busy_idle", busy, 0);
        end
        yModel = eY;
    endtask

    initial begin
        logic [W-1:0] aSeq [13];
        logic [W-1:0] bh;
        logic         ch;
        logic [W-1:0] eY;
        logic         eC, eO, eZ;
        logic         expDone;

        // Reset values
        #12;
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_y", y, 0);
        checkVal("rst_cout", carry_out, 0);
        checkVal("rst_ovf", overflow, 0);
        checkVal("rst_zero", zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Accumulate from zero after reset, then a wrapping accumulate
        runOp(OP_ACC, 8'h10, 8'hAA, 1'b0);
        checkVal("acc1_y", y, 8'h10);
        runOp(OP_ACC, 8'h10, 8'h55, 1'b0);
        checkVal("acc2_y", y, 8'h20);
        runOp(OP_ACC, 8'hF0, 8'h00, 1'b0);
        checkVal("acc3_y", y, 8'h10);
        checkVal("acc3_cout", carry_out, 1);

        // Signed overflow and subtraction with and without borrow-in
        runOp(OP_ADD, 8'h7F, 8'h01, 1'b0);
        runOp(OP_SUB, 8'h05, 8'h07, 1'b0);
        checkVal("sub1_y", y, 8'hFE);
        runOp(OP_SUB, 8'h07, 8'h05, 1'b1);
        checkVal("sub2_y", y, 8'h01);

        // Reset in the middle of an operation: abort, no done
        @(negedge clk);
        start = 1'b1; op = OP_ADD; a = 8'h33; b = 8'h44; carry_in = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkVal("abort_busy", busy, 0);
        checkVal("abort_y", y, 0);
        checkVal("abort_done", done, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkVal("abort_nodone", done, 0);
        end
        rst_n = 1'b1;
        yModel = '0;
        runOp(OP_ADD, 8'h01, 8'h01, 1'b0);
        checkVal("post_rst_y", y, 8'h02);

        // NOP still runs the full sequence and reports zero
        runOp(OP_NOP, 8'hFF, 8'hFF, 1'b1);

        // start held high while a changes every cycle
        for (int i = 0; i < 13; i++) aSeq[i] = 8'($urandom);
        bh = 8'($urandom);
        ch = 1'($urandom);
        @(negedge clk);
        op = OP_ADD; b = bh; carry_in = ch; start = 1'b1; a = aSeq[0];
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            @(negedge clk);
            expDone = ((e % (N + 2)) == (N + 1));
            checkVal("b2b_done", done, 32'(expDone));
            if (expDone) begin
                calcExp(OP_ADD, aSeq[e - (N + 1)], bh, ch, eY, eC, eO, eZ);
                checkVal("b2b_y", y, eY);
                checkVal("b2b_cout", carry_out, eC);
                yModel = eY;
            end
            a = aSeq[e + 1];
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Random operations
        for (int i = 0; i < 150; i++) begin
            runOp(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/arith_unit_serial.md
ARITH_UNIT_SERIAL -- requirements
Module: arith_unit_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be a multiple of DIGIT and at least 4.
REQ-002 Parameter DIGIT, default 4, bits processed per clock cycle; N = WIDTH/DIGIT cycles per operation.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request; SHALL be sampled only in IDLE.
REQ-006 op  input  2  opcode: 00 NOP, 01 ADD, 10 SUB, 11 ACC.
REQ-007 a, b  input  WIDTH  operands, two's complement.
REQ-008 carry_in  input  1  carry-in for ADD/ACC, borrow-in for SUB.
REQ-009 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-010 done  output  1  one-cycle pulse; results valid from this cycle until the next done.
REQ-011 y  output  WIDTH  registered result.
REQ-012 carry_out, overflow, zero  output  1 each  registered flags: final-digit carry, signed overflow, y equal to 0.

Function
REQ-013 FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after N RUN cycles, DONE->IDLE unconditionally.
REQ-014 On accepted start: a, b, op, carry_in latched; digit counter cleared; start ignored in RUN and DONE.
REQ-015 Each RUN cycle SHALL add one DIGIT-bit slice, LSB first, propagating carry between slices in an internal register.
REQ-016 Latency: start sampled at edge k -> done high in the cycle following edge k+N+1; busy high from edge k+1 through the done cycle.
REQ-017 ADD: y = a + b + carry_in mod 2^WIDTH; carry_out = carry out of bit WIDTH-1.
REQ-018 SUB: y = a + ~b + !carry_in (i.e. a - b - carry_in); carry_out = 1 means no borrow.
REQ-019 ACC: y = y_prev + a + carry_in, where y_prev is the y held at start; b ignored.
REQ-020 NOP: SHALL run the full N-cycle sequence; y = 0, carry_out = 0, overflow = 0, zero = 1.
REQ-021 overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (0 for NOP).
REQ-022 y and flags SHALL update only in the cycle done is raised; otherwise hold.
REQ-023 Changes on a, b, op, carry_in after start is accepted SHALL NOT affect the running operation.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new start is accepted the following cycle (back-to-back throughput N+2 cycles).

Reset
REQ-025 rst_n low SHALL immediately force IDLE, busy = 0, done = 0, y = 0, carry_out = 0, overflow = 0, zero = 0, internal carry and counter = 0.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; ACC after reset accumulates from 0.
REQ-027 Release of rst_n SHALL take effect on the next rising clk; first start accepted at that edge.

Configuration
REQ-028 Macro ARITH_SAT_EN: when defined, on overflow y SHALL saturate to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow); overflow flag still set; zero computed on saturated y.
REQ-029 When ARITH_SAT_EN is undefined, y SHALL wrap modulo 2^WIDTH with no saturation logic present.

Verification (WIDTH=8, DIGIT=4, N=2)
REQ-030 ADD a=0x7F b=0x01 cin=0 -> done 3 cycles after start edge; y=0x80, overflow=1, carry_out=0, zero=0; with ARITH_SAT_EN y=0x7F.
REQ-031 SUB a=0x05 b=0x07 cin=0 -> y=0xFE, carry_out=0, overflow=0; SUB a=0x07 b=0x05 cin=1 -> y=0x01, carry_out=1.
REQ-032 After reset, ACC a=0x10 cin=0 twice -> y=0x10 then 0x20; ACC a=0xF0 cin=0 from y=0x20 -> y=0x10, carry_out=1.
REQ-033 start held high across an operation with changing a -> exactly one done per N+2 cycles, results from operands at acceptance.
REQ-034 rst_n low during RUN cycle 1 -> busy=0, y=0, no done; next ADD 0x01+0x01 -> y=0x02.
REQ-035 NOP with a=0xFF b=0xFF cin=1 -> y=0x00, zero=1, carry_out=0, overflow=0, done after 3 cycles.
